mips_bus_arbiter: RTL and testbench
===================================

# mips_bus_arbiter

Two-master arbiter that shares the single memory bus of the MIPS system between two requesters. Master 0 is the CPU (`mips_cpu_bus`) and master 1 is the test loader/DMA port. The arbiter registers each granted command and drives it onto the memory-side read/write/waitrequest bus, and it completes each transfer back to the requester with a one-cycle `waitrequest` release. It sits between the masters and the memory model or RAM, so neither master sees the other's traffic.

## Interface
- `ADDR_W`, 32, address width of masters and memory
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`
- `FIXED_PRIO`, 0, 0 = round-robin; 1 = master 0 always wins a tie

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `m0_address` / `m1_address` in `ADDR_W`: master byte address.
- `m0_read` / `m1_read` in 1: read request.
- `m0_write` / `m1_write` in 1: write request.
- `m0_writedata` / `m1_writedata` in `DATA_W`: write data.
- `m0_byteenable` / `m1_byteenable` in `DATA_W/8`: byte lanes.
- `m0_waitrequest` / `m1_waitrequest` out 1: low for exactly one cycle when that master's transfer completes.
- `m0_readdata` / `m1_readdata` out `DATA_W`: read result, valid while the matching waitrequest is low.
- `s_address` out `ADDR_W`: memory address.
- `s_read` out 1: memory read strobe.
- `s_write` out 1: memory write strobe.
- `s_writedata` out `DATA_W`: memory write data.
- `s_byteenable` out `DATA_W/8`: memory byte lanes.
- `s_waitrequest` in 1: memory stall.
- `s_readdata` in `DATA_W`: memory read data, valid the cycle after the read is accepted.

## Operation
States are IDLE, ISSUE, RDATA and RESP.

- **IDLE**
  - A master is requesting when `read|write` is asserted.
  - If both masters request, the winner is chosen as follows:
    - With `FIXED_PRIO=0`, the winner is the master not granted last.
    - With `FIXED_PRIO=1`, the winner is master 0.
  - On grant:
    - Register the winner's address, writedata, byteenable and operation into the command register.
    - Record the winner in `grant`.
    - Go to ISSUE.
  - If a master asserts both `read` and `write`, the request is a write and `read` is ignored.
- **ISSUE**
  - `s_read`/`s_write` reflect the registered operation.
  - Stay in ISSUE while `s_waitrequest=1`.
  - When `s_waitrequest=0`, a write goes to RESP and a read goes to RDATA.
- **RDATA**
  - Capture `s_readdata` into the read-data register.
  - Go to RESP.
- **RESP**
  - `m<grant>_waitrequest=0`.
  - `m<grant>_readdata` = captured data (or the previous captured value for a write).
  - Set `last_grant=grant`.
  - Go to IDLE.

Rules that hold in every state:
- The command is registered at grant. Master inputs that change after grant do not affect the transfer in progress.
- `s_read` and `s_write` are 0 outside ISSUE. `s_address`, `s_writedata` and `s_byteenable` hold the last registered command.
- `mN_waitrequest` is 1 at all times except in RESP with `grant==N`. An idle master therefore sees waitrequest high.
- Both `mN_readdata` outputs are driven from the same captured register.

## Timing
- **Reset values:**
  - State = IDLE.
  - `s_read`, `s_write` = 0.
  - `s_address`, `s_writedata` = 0; `s_byteenable` = 0.
  - Read-data register = 0.
  - Both `mN_waitrequest` = 1.
  - `last_grant` = 1, so master 0 wins the first tie.
- **Write latency** with no memory stall: request seen in IDLE at cycle 0, `s_write` high in cycle 1, `mN_waitrequest` low in cycle 2. Each stall cycle adds 1.
- **Read latency** with no memory stall: IDLE cycle 0, ISSUE cycle 1, RDATA cycle 2, RESP cycle 3 with data valid. Each stall cycle adds 1.
- **Throughput:** at most one transfer per 3 cycles (write) or 4 cycles (read). There is no pipelining.
- A master still requesting after its RESP re-enters arbitration in the next IDLE cycle. Under round-robin, a waiting other master wins that cycle.
- **Simultaneous new request during a transfer:** the new request waits with waitrequest high and is considered in the next IDLE.
- **Reset asserted mid-transfer:**
  - All outputs return to their reset values immediately (asynchronously).
  - The transfer is abandoned.
  - No master sees a completion.
- **Address handling:** widths pass through unchanged; the arbiter does no address mapping.

## Test plan
- **Single CPU read:** reset, then `m0_read=1`, `m0_address=32'hBFC00008`, with memory returning 32'h8D02002C the cycle after acceptance. Required: `s_read` high in cycle 1 only, `m0_waitrequest` low in cycle 3 only, `m0_readdata=32'h8D02002C`.
- **Contention, round-robin:**
  - Stimulus: both masters issue writes continuously after reset (m0 data 32'hA, m1 data 32'h22).
  - Required: grant order is m0, m1, m0, m1.
  - Required: `s_writedata` alternates between 32'hA and 32'h22.
  - Required: each master's waitrequest is released once per 6 cycles.
- **Fixed priority:** `FIXED_PRIO=1` with both masters requesting continuously. Required: m1 never completes; m0 completes every 3 cycles.
- **Memory stall:** `s_waitrequest=1` held for 4 cycles during an m1 read, with m1 changing `m1_address` during the stall. Required: `s_read` stays high for 5 cycles, `s_address` stays at the original value, and completion comes 4 cycles later than the unstalled case.
- **Reset mid-read:** assert `reset` in RDATA. Required: `s_read=0` and both waitrequests=1 immediately. After release, a pending m0 request is granted first.
- **Read+write together:** m0 asserts both, with `m0_byteenable=4'b0011`. Required: `s_write=1`, `s_read=0`, `s_byteenable=4'b0011`, and completion in cycle 2.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter for the MIPS memory bus: master 0 is the CPU, master 1 the loader/DMA port.
// Only one registered command is in flight at a time. Each transfer completes with a one-cycle waitrequest release.
module mips_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic                grant_q;
    logic                last_grant_q;
    logic                cmd_write_q;
    logic                s_read_q;
    logic                s_write_q;
    logic                m0_wait_q;
    logic                m1_wait_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [BE_W-1:0]     be_q;

    logic                m0_req_s;
    logic                m1_req_s;
    logic                grant_d;
    logic                write_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [BE_W-1:0]     be_d;

    // Request detection, tie-break and selection of the command to register at grant
    always_comb begin
        m0_req_s = m0_read | m0_write;
        m1_req_s = m1_read | m1_write;
        if (m0_req_s && m1_req_s) begin
            grant_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else if (m1_req_s) begin
            grant_d = 1'b1;
        end else begin
            grant_d = 1'b0;
        end
        // write wins over read when a master asserts both
        if (grant_d) begin
            addr_d  = m1_address;
            wdata_d = m1_writedata;
            be_d    = m1_byteenable;
            write_d = m1_write;
        end else begin
            addr_d  = m0_address;
            wdata_d = m0_writedata;
            be_d    = m0_byteenable;
            write_d = m0_write;
        end
    end

    // Transfer FSM with registered bus strobes and completion signals
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_write_q  <= 1'b0;
            s_read_q     <= 1'b0;
            s_write_q    <= 1'b0;
            m0_wait_q    <= 1'b1;
            m1_wait_q    <= 1'b1;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            rdata_q      <= {DATA_W{1'b0}};
            be_q         <= {BE_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_req_s || m1_req_s) begin
                        grant_q     <= grant_d;
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        be_q        <= be_d;
                        cmd_write_q <= write_d;
                        s_write_q   <= write_d;
                        s_read_q    <= ~write_d;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!s_waitrequest) begin
                        s_read_q  <= 1'b0;
                        s_write_q <= 1'b0;
                        if (cmd_write_q) begin
                            state_q   <= ST_RESP;
                            m0_wait_q <= grant_q;
                            m1_wait_q <= ~grant_q;
                        end else begin
                            state_q <= ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    rdata_q   <= s_readdata;
                    state_q   <= ST_RESP;
                    m0_wait_q <= grant_q;
                    m1_wait_q <= ~grant_q;
                end
                ST_RESP: begin
                    m0_wait_q    <= 1'b1;
                    m1_wait_q    <= 1'b1;
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_read_q  <= 1'b0;
                    s_write_q <= 1'b0;
                    m0_wait_q <= 1'b1;
                    m1_wait_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_address      = addr_q;
    assign s_writedata    = wdata_q;
    assign s_byteenable   = be_q;
    assign s_read         = s_read_q;
    assign s_write        = s_write_q;
    assign m0_waitrequest = m0_wait_q;
    assign m1_waitrequest = m1_wait_q;
    assign m0_readdata    = rdata_q;
    assign m1_readdata    = rdata_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: one round-robin instance with a memory responder,
// plus a fixed-priority instance that sees continuous writes from both masters.
module tb_mips_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [31:0] s_readdata;
    logic [31:0] mem_rd_val;

    logic [31:0] f_m0_address, f_m1_address, f_s_address;
    logic        f_m0_write, f_m1_write, f_s_read, f_s_write;
    logic [31:0] f_m0_writedata, f_m1_writedata, f_s_writedata;
    logic [3:0]  f_m0_byteenable, f_m1_byteenable, f_s_byteenable;
    logic        f_m0_waitrequest, f_m1_waitrequest;
    logic [31:0] f_m0_readdata, f_m1_readdata;
    logic        f_s_waitrequest;
    logic [31:0] f_s_readdata;

    typedef struct {
        int          master;
        logic [31:0] data;
        int          cycle;
        bit          chk;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          om;
    logic [31:0] ord;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    // memory answers one cycle after an accepted read, garbage otherwise
    always @(posedge clk) begin
        if (s_read && !s_waitrequest) s_readdata <= mem_rd_val;
        else                          s_readdata <= 32'hDEADBEEF;
    end

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
    );

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fixed (
        .clk(clk), .reset(reset),
        .m0_address(f_m0_address), .m0_read(1'b0), .m0_write(f_m0_write),
        .m0_writedata(f_m0_writedata), .m0_byteenable(f_m0_byteenable),
        .m0_waitrequest(f_m0_waitrequest), .m0_readdata(f_m0_readdata),
        .m1_address(f_m1_address), .m1_read(1'b0), .m1_write(f_m1_write),
        .m1_writedata(f_m1_writedata), .m1_byteenable(f_m1_byteenable),
        .m1_waitrequest(f_m1_waitrequest), .m1_readdata(f_m1_readdata),
        .s_address(f_s_address), .s_read(f_s_read), .s_write(f_s_write),
        .s_writedata(f_s_writedata), .s_byteenable(f_s_byteenable),
        .s_waitrequest(f_s_waitrequest), .s_readdata(f_s_readdata)
    );

    task automatic check_sb_empty(input string name);
        total_cnt++;
        if (sb_q.size() != 0)
            $display("FAIL %s_missing: %0d completions never seen, required 0", name, sb_q.size());
        else
            pass_cnt++;
        sb_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({s_read, s_write} !== 2'b00) $display("FAIL reset_strobes: got %b, required 00", {s_read, s_write});
        else pass_cnt++;
        total_cnt++;
        if ({s_address, s_writedata, s_byteenable} !== 68'h0)
            $display("FAIL reset_cmd: got %h %h %h, required zeros", s_address, s_writedata, s_byteenable);
        else pass_cnt++;
        total_cnt++;
        if ({m0_waitrequest, m1_waitrequest, f_m0_waitrequest, f_m1_waitrequest} !== 4'b1111)
            $display("FAIL reset_wait: got %b, required 1111", {m0_waitrequest, m1_waitrequest, f_m0_waitrequest, f_m1_waitrequest});
        else pass_cnt++;
        total_cnt++;
        if ({m0_readdata, m1_readdata} !== 64'h0)
            $display("FAIL reset_rdata: got %h %h, required 0", m0_readdata, m1_readdata);
        else pass_cnt++;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({m0_waitrequest, m1_waitrequest, s_read, s_write} !== 4'b1100)
            $display("FAIL idle_after_reset: got %b, required 1100", {m0_waitrequest, m1_waitrequest, s_read, s_write});
        else pass_cnt++;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        mem_rd_val = 32'h8D02002C;
        m0_address = 32'hBFC00008;
        m0_read    = 1'b1;
        sb_q.push_back('{0, 32'h8D02002C, 3, 1'b1});
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); @(negedge clk);
            total_cnt++;
            if (s_read !== (k == 1)) $display("FAIL single_read_sread: cycle %0d got %b, required %b", k, s_read, (k == 1));
            else pass_cnt++;
            if (k == 1) begin
                total_cnt++;
                if (s_address !== 32'hBFC00008) $display("FAIL single_read_addr: got %h, required bfc00008", s_address);
                else pass_cnt++;
            end
            if (m0_waitrequest === 1'b0 || m1_waitrequest === 1'b0) begin
                om  = (m0_waitrequest === 1'b0) ? 0 : 1;
                ord = (om == 0) ? m0_readdata : m1_readdata;
                total_cnt++;
                if (sb_q.size() == 0) $display("FAIL single_read_done: unexpected completion m%0d cycle %0d", om, k);
                else begin
                    e = sb_q.pop_front();
                    if (om != e.master || k != e.cycle || (e.chk && ord !== e.data))
                        $display("FAIL single_read_done: got m%0d cycle %0d data %h, required m%0d cycle %0d data %h", om, k, ord, e.master, e.cycle, e.data);
                    else pass_cnt++;
                end
                m0_read = 1'b0;
            end
        end
        check_sb_empty("single_read");
    endtask

    task automatic test_round_robin();
        logic [31:0] wd_exp;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m0_address = 32'h00000100; m0_writedata = 32'h0000000A; m0_byteenable = 4'hF; m0_write = 1'b1;
        m1_address = 32'h00000200; m1_writedata = 32'h00000022; m1_byteenable = 4'hF; m1_write = 1'b1;
        sb_q.push_back('{0, 32'h0, 2, 1'b0});
        sb_q.push_back('{1, 32'h0, 5, 1'b0});
        sb_q.push_back('{0, 32'h0, 8, 1'b0});
        sb_q.push_back('{1, 32'h0, 11, 1'b0});
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (k % 3 == 1) begin
                wd_exp = (((k - 1) / 3) % 2 == 0) ? 32'h0000000A : 32'h00000022;
                total_cnt++;
                if (s_write !== 1'b1 || s_writedata !== wd_exp)
                    $display("FAIL rr_wdata: cycle %0d got write=%b data %h, required write=1 data %h", k, s_write, s_writedata, wd_exp);
                else pass_cnt++;
            end
            if (m0_waitrequest === 1'b0 || m1_waitrequest === 1'b0) begin
                om = (m0_waitrequest === 1'b0) ? 0 : 1;
                total_cnt++;
                if (sb_q.size() == 0) $display("FAIL rr_done: unexpected completion m%0d cycle %0d", om, k);
                else begin
                    e = sb_q.pop_front();
                    if (om != e.master || k != e.cycle)
                        $display("FAIL rr_done: got m%0d cycle %0d, required m%0d cycle %0d", om, k, e.master, e.cycle);
                    else pass_cnt++;
                end
            end
            if (k == 11) begin
                m0_write = 1'b0;
                m1_write = 1'b0;
            end
        end
        check_sb_empty("rr");
    endtask

    task automatic test_fixed_prio();
        int m1_done = 0;
        @(posedge clk); #1;
        f_m0_writedata = 32'h0000000A; f_m1_writedata = 32'h00000022;
        f_m0_write = 1'b1; f_m1_write = 1'b1;
        for (int c = 2; c <= 11; c += 3) sb_q.push_back('{0, 32'h0, c, 1'b0});
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (f_m1_waitrequest === 1'b0) m1_done++;
            if (k % 3 == 1) begin
                total_cnt++;
                if (f_s_write !== 1'b1 || f_s_writedata !== 32'h0000000A)
                    $display("FAIL fixed_wdata: cycle %0d got write=%b data %h, required write=1 data 0000000a", k, f_s_write, f_s_writedata);
                else pass_cnt++;
            end
            if (f_m0_waitrequest === 1'b0) begin
                total_cnt++;
                if (sb_q.size() == 0) $display("FAIL fixed_done: unexpected m0 completion cycle %0d", k);
                else begin
                    e = sb_q.pop_front();
                    if (k != e.cycle) $display("FAIL fixed_done: got m0 cycle %0d, required cycle %0d", k, e.cycle);
                    else pass_cnt++;
                end
            end
        end
        f_m0_write = 1'b0; f_m1_write = 1'b0;
        total_cnt++;
        if (m1_done != 0) $display("FAIL fixed_m1_starved: got %0d m1 completions, required 0", m1_done);
        else pass_cnt++;
        check_sb_empty("fixed");
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        mem_rd_val    = 32'h12345678;
        m1_address    = 32'h10000040;
        m1_read       = 1'b1;
        s_waitrequest = 1'b1;
        sb_q.push_back('{1, 32'h12345678, 7, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); @(negedge clk);
            total_cnt++;
            if (s_read !== (k <= 5) || s_address !== 32'h10000040)
                $display("FAIL stall_bus: cycle %0d got read=%b addr %h, required read=%b addr 10000040", k, s_read, s_address, (k <= 5));
            else pass_cnt++;
            if (k == 2) m1_address = 32'hFFFFFFF0;
            if (k == 5) s_waitrequest = 1'b0;
            if (m0_waitrequest === 1'b0 || m1_waitrequest === 1'b0) begin
                om  = (m0_waitrequest === 1'b0) ? 0 : 1;
                ord = (om == 0) ? m0_readdata : m1_readdata;
                total_cnt++;
                if (sb_q.size() == 0) $display("FAIL stall_done: unexpected completion m%0d cycle %0d", om, k);
                else begin
                    e = sb_q.pop_front();
                    if (om != e.master || k != e.cycle || ord !== e.data)
                        $display("FAIL stall_done: got m%0d cycle %0d data %h, required m%0d cycle %0d data %h", om, k, ord, e.master, e.cycle, e.data);
                    else pass_cnt++;
                end
                m1_read = 1'b0;
            end
        end
        check_sb_empty("stall");
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        mem_rd_val = 32'hCAFE0001;
        m0_address = 32'h00000400;
        m0_read    = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        m1_address = 32'h00000800;
        m1_read    = 1'b1;
        #1;
        total_cnt++;
        if ({s_read, s_write, m0_waitrequest, m1_waitrequest} !== 4'b0011 || s_address !== 32'h0 || m0_readdata !== 32'h0)
            $display("FAIL midreset_async: got rd=%b wr=%b w0=%b w1=%b addr %h rdata %h, required 0 0 1 1 0 0",
                     s_read, s_write, m0_waitrequest, m1_waitrequest, s_address, m0_readdata);
        else pass_cnt++;
        @(posedge clk); @(negedge clk);
        total_cnt++;
        if ({m0_waitrequest, m1_waitrequest, s_read} !== 3'b110)
            $display("FAIL midreset_hold: got %b, required 110", {m0_waitrequest, m1_waitrequest, s_read});
        else pass_cnt++;
        @(posedge clk); #1 reset = 1'b0;
        sb_q.push_back('{0, 32'hCAFE0001, 3, 1'b1});
        sb_q.push_back('{1, 32'hCAFE0001, 7, 1'b1});
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) begin
                total_cnt++;
                if (s_address !== 32'h00000400) $display("FAIL midreset_first: got addr %h, required 00000400", s_address);
                else pass_cnt++;
            end
            if (m0_waitrequest === 1'b0 || m1_waitrequest === 1'b0) begin
                om  = (m0_waitrequest === 1'b0) ? 0 : 1;
                ord = (om == 0) ? m0_readdata : m1_readdata;
                total_cnt++;
                if (sb_q.size() == 0) $display("FAIL midreset_done: unexpected completion m%0d cycle %0d", om, k);
                else begin
                    e = sb_q.pop_front();
                    if (om != e.master || k != e.cycle || ord !== e.data)
                        $display("FAIL midreset_done: got m%0d cycle %0d data %h, required m%0d cycle %0d data %h", om, k, ord, e.master, e.cycle, e.data);
                    else pass_cnt++;
                end
                if (om == 0) m0_read = 1'b0;
                else         m1_read = 1'b0;
            end
        end
        check_sb_empty("midreset");
    endtask

    task automatic test_read_write_both();
        @(posedge clk); #1;
        m0_address    = 32'h00000020;
        m0_writedata  = 32'h5555AAAA;
        m0_byteenable = 4'b0011;
        m0_read       = 1'b1;
        m0_write      = 1'b1;
        sb_q.push_back('{0, 32'hCAFE0001, 2, 1'b1});
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1) begin
                total_cnt++;
                if ({s_write, s_read} !== 2'b10 || s_byteenable !== 4'b0011 || s_writedata !== 32'h5555AAAA)
                    $display("FAIL rw_issue: got wr=%b rd=%b be=%b data %h, required 1 0 0011 5555aaaa", s_write, s_read, s_byteenable, s_writedata);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if ({s_write, s_read} !== 2'b00) $display("FAIL rw_strobe: cycle %0d got %b, required 00", k, {s_write, s_read});
                else pass_cnt++;
            end
            if (m0_waitrequest === 1'b0 || m1_waitrequest === 1'b0) begin
                om  = (m0_waitrequest === 1'b0) ? 0 : 1;
                ord = (om == 0) ? m0_readdata : m1_readdata;
                total_cnt++;
                if (sb_q.size() == 0) $display("FAIL rw_done: unexpected completion m%0d cycle %0d", om, k);
                else begin
                    e = sb_q.pop_front();
                    if (om != e.master || k != e.cycle || ord !== e.data)
                        $display("FAIL rw_done: got m%0d cycle %0d data %h, required m%0d cycle %0d data %h", om, k, ord, e.master, e.cycle, e.data);
                    else pass_cnt++;
                end
                m0_read  = 1'b0;
                m0_write = 1'b0;
            end
        end
        check_sb_empty("rw");
    endtask

    initial begin
        m0_address = 32'h0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'h0; m0_byteenable = 4'h0;
        m1_address = 32'h0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'h0; m1_byteenable = 4'h0;
        s_waitrequest = 1'b0; mem_rd_val = 32'h0;
        f_m0_address = 32'h00000010; f_m1_address = 32'h00000020;
        f_m0_write = 1'b0; f_m1_write = 1'b0;
        f_m0_writedata = 32'h0; f_m1_writedata = 32'h0;
        f_m0_byteenable = 4'hF; f_m1_byteenable = 4'hF;
        f_s_waitrequest = 1'b0; f_s_readdata = 32'h0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_stall();
        test_reset_mid_read();
        test_read_write_both();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
